// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: drives pll_rst, qualifies pll_locked and gates core_rst.
// Optional macro PLL_LOSS_COUNT_EN adds an 8-bit saturating lock-loss counter output.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 50,
    parameter int STABLE_CYCLES = 500000,
    parameter int LOCK_TIMEOUT  = 5000000,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 24
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retries,
    input  logic       relock_req,
    output logic       relock_ack
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_LAST  = 4'(MAX_RETRY);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_next;
    logic [3:0]       retries_next;
    logic             ack_next;
    logic             lock_loss;
    logic             lock_p0;
    logic             lock_p1;

    // Stage p0/p1: two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= pll_locked;
            lock_p1 <= lock_p0;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state      <= RESET_PLL;
            counter    <= '0;
            retries    <= 4'd0;
            relock_ack <= 1'b0;
            pll_rst    <= 1'b1;
            core_rst   <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            retries    <= retries_next;
            relock_ack <= ack_next;
            // Outputs decode the next state so they change on the transition edge
            pll_rst    <= (state_next == RESET_PLL);
            core_rst   <= (state_next != RUN);
            ready      <= (state_next == RUN);
            fail       <= (state_next == FAIL);
        end
    end

    always_comb begin
        state_next   = state;
        retries_next = retries;
        ack_next     = 1'b0;
        lock_loss    = 1'b0;
        case (state)
            RESET_PLL: begin
                if (counter == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_p1) begin
                    state_next = STABLE;
                end else if (counter == TIMEOUT_LAST) begin
                    if (retries == RETRY_LAST) begin
                        state_next = FAIL;
                    end else begin
                        retries_next = retries + 4'd1;
                        state_next   = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!lock_p1) begin
                    state_next = WAIT_LOCK;
                end else if (counter == STABLE_LAST) begin
                    state_next   = RUN;
                    retries_next = 4'd0;
                end
            end
            RUN: begin
                retries_next = 4'd0;
                // Lock loss wins the classification, but a pending request is still acked
                if (!lock_p1) begin
                    lock_loss  = 1'b1;
                    state_next = RESET_PLL;
                    ack_next   = relock_req;
                end else if (relock_req) begin
                    state_next = RESET_PLL;
                    ack_next   = 1'b1;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    state_next   = RESET_PLL;
                    retries_next = 4'd0;
                    ack_next     = 1'b1;
                end
            end
            default: begin
                state_next = RESET_PLL;
            end
        endcase
        counter_next = (state_next != state) ? '0 : counter + CNT_W'(1);
    end

`ifdef PLL_LOSS_COUNT_EN
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_count <= 8'd0;
        end else if (lock_loss && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected output changes
// with their cycle stamps; a negedge monitor pops and compares on every output change.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retries;
    logic       relock_req;
    logic       relock_ack;
`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .STABLE_CYCLES (8),
        .LOCK_TIMEOUT  (32),
        .MAX_RETRY     (2),
        .CNT_W         (24)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .fail       (fail),
        .retries    (retries),
        .relock_req (relock_req),
        .relock_ack (relock_ack)
`ifdef PLL_LOSS_COUNT_EN
        ,
        .loss_count (loss_count)
`endif
    );

    typedef struct {
        int         cyc;
        logic [8:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 0;
    logic [8:0] prev_vec = '0;

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [8:0] out_vec();
        return {pll_rst, core_rst, ready, fail, retries, relock_ack};
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [8:0] act, input logic [8:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%b required=%b (pll_rst,core_rst,ready,fail,retries[4],ack)",
                     name, cyc, act, req);
        end
    endtask

    task automatic expect_at(input int c, input bit pr, input bit cr, input bit rd,
                             input bit fl, input int rt, input bit ak);
        exp_t e;
        e.cyc = c;
        e.vec = {pr, cr, rd, fl, 4'(rt), ak};
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    // Monitor: every change of the output vector must match the next queued event
    always @(negedge refclk) begin
        exp_t       e;
        logic [8:0] cur;
        cur = out_vec();
        if (mon_en && (cur !== prev_vec)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_change at cycle %0d: actual=%b required=no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                check_int("event_cycle", cyc, e.cyc);
                check_vec("event_outputs", cur, e.vec);
            end
        end
        prev_vec = cur;
    end

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        @(negedge refclk);
        wait_cyc(3);

        check_int("reset_pll_rst", int'(pll_rst), 1);
        check_int("reset_core_rst", int'(core_rst), 1);
        check_int("reset_ready", int'(ready), 0);
        check_int("reset_fail", int'(fail), 0);
        check_int("reset_retries", int'(retries), 0);
        check_int("reset_relock_ack", int'(relock_ack), 0);
`ifdef PLL_LOSS_COUNT_EN
        check_int("reset_loss_count", int'(loss_count), 0);
`endif
        mon_en = 1'b1;

        // Cold start: pll_rst high 4 cycles, core released 11 cycles after lock
        expect_at(7,  0, 1, 0, 0, 0, 0);
        expect_at(24, 0, 0, 1, 0, 0, 0);
        rst_n = 1'b1;
        wait_cyc(13);
        pll_locked = 1'b1;

        // Lock loss in RUN: reset 3 cycles after the drop, pll_rst for 4 cycles
        expect_at(33, 1, 1, 0, 0, 0, 0);
        expect_at(37, 0, 1, 0, 0, 0, 0);
        wait_cyc(30);
        pll_locked = 1'b0;
`ifdef PLL_LOSS_COUNT_EN
        wait_cyc(34);
        check_int("loss_count_first", int'(loss_count), 1);
`endif

        // Glitch in STABLE after 5 stable cycles: fresh 8-cycle qualification
        expect_at(59, 0, 0, 1, 0, 0, 0);
        wait_cyc(40);
        pll_locked = 1'b1;
        wait_cyc(45);
        pll_locked = 1'b0;
        wait_cyc(48);
        pll_locked = 1'b1;

        // Relock request from RUN
        expect_at(63, 1, 1, 0, 0, 0, 1);
        expect_at(64, 1, 1, 0, 0, 0, 0);
        expect_at(67, 0, 1, 0, 0, 0, 0);
        expect_at(76, 0, 0, 1, 0, 0, 0);
        wait_cyc(62);
        relock_req = 1'b1;
        wait_cyc(63);
        relock_req = 1'b0;

        // Request held during STABLE is acked only after RUN is reached
        expect_at(83,  1, 1, 0, 0, 0, 0);
        expect_at(87,  0, 1, 0, 0, 0, 0);
        expect_at(101, 0, 0, 1, 0, 0, 0);
        expect_at(102, 1, 1, 0, 0, 0, 1);
        expect_at(103, 1, 1, 0, 0, 0, 0);
        expect_at(106, 0, 1, 0, 0, 0, 0);
        expect_at(115, 0, 0, 1, 0, 0, 0);
        wait_cyc(80);
        pll_locked = 1'b0;
        wait_cyc(90);
        pll_locked = 1'b1;
        wait_cyc(95);
        relock_req = 1'b1;
        wait_cyc(102);
        relock_req = 1'b0;

        // Simultaneous lock loss and relock request in RUN: one entry, one ack
        expect_at(123, 1, 1, 0, 0, 0, 1);
        expect_at(124, 1, 1, 0, 0, 0, 0);
        expect_at(127, 0, 1, 0, 0, 0, 0);
        // Lock never returns: two retries then FAIL
        expect_at(159, 1, 1, 0, 0, 1, 0);
        expect_at(163, 0, 1, 0, 0, 1, 0);
        expect_at(195, 1, 1, 0, 0, 2, 0);
        expect_at(199, 0, 1, 0, 0, 2, 0);
        expect_at(231, 0, 1, 0, 1, 2, 0);
        wait_cyc(120);
        pll_locked = 1'b0;
        wait_cyc(122);
        relock_req = 1'b1;
        wait_cyc(123);
        relock_req = 1'b0;
`ifdef PLL_LOSS_COUNT_EN
        wait_cyc(124);
        check_int("loss_count_simultaneous", int'(loss_count), 3);
`endif

        // Relock from FAIL clears fail and retries
        expect_at(241, 1, 1, 0, 0, 0, 1);
        expect_at(242, 1, 1, 0, 0, 0, 0);
        expect_at(245, 0, 1, 0, 0, 0, 0);
        expect_at(258, 0, 0, 1, 0, 0, 0);
        wait_cyc(240);
        check_int("fail_held_pll_rst", int'(pll_rst), 0);
        relock_req = 1'b1;
        wait_cyc(241);
        relock_req = 1'b0;
        wait_cyc(247);
        pll_locked = 1'b1;

        // Reset from RUN
        expect_at(266, 1, 1, 0, 0, 0, 0);
        wait_cyc(265);
        rst_n = 1'b0;
`ifdef PLL_LOSS_COUNT_EN
        wait_cyc(267);
        check_int("loss_count_cleared", int'(loss_count), 0);
`endif

        wait_cyc(280);
        check_int("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
